// File: rtl/memory_responder.sv
// Single-cycle RAM + MMIO responder for a simple CPU bus, with registered read data.
// Optional MMIO window (cycle counter, LEDs, sticky status) enabled by MEMORY_RESPONDER_MMIO_EN.
module memory_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_FFF0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic [7:0]  led_o
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic          is_ram;
  logic [31:0]   data_d, data_q;

  assign idx    = addr_i[AW+1:2];
  assign is_ram = addr_i < RAM_BYTES;

`ifdef MEMORY_RESPONDER_MMIO_EN
  logic        mmio_hit;
  logic [1:0]  off;
  logic [1:0]  status_set, status_clr;
  logic [31:0] cnt_d, cnt_q;
  logic [7:0]  led_d, led_q;
  logic [1:0]  status_d, status_q;

  // RAM decode wins if a badly chosen MMIO_BASE overlaps the RAM range.
  assign mmio_hit = (addr_i[31:4] == MMIO_BASE[31:4]) && !is_ram;
  assign off      = addr_i[3:2];

  always_comb begin
    cnt_d      = cnt_q + 32'd1;
    led_d      = led_q;
    status_clr = 2'b00;
    status_set = {addr_i[1:0] != 2'b00, !is_ram && !mmio_hit};
    if (mmio_hit && we_i) begin
      case (off)
        2'd0:    cnt_d      = data_i;
        2'd1:    led_d      = data_i[7:0];
        2'd2:    status_clr = data_i[1:0];
        default: ;
      endcase
    end
    status_d = status_set | (status_q & ~status_clr);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q    <= '0;
      led_q    <= '0;
      status_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      led_q    <= led_d;
      status_q <= status_d;
    end
  end

  assign led_o = led_q;
`else
  // Window address still a parameter of the block; nothing decodes it in this build.
  logic unused_mmio_base;
  assign unused_mmio_base = ^MMIO_BASE;
  assign led_o            = '0;
`endif

  always_comb begin
    data_d = '0;
    if (is_ram) begin
      data_d = we_i ? data_i : mem[idx];
    end
`ifdef MEMORY_RESPONDER_MMIO_EN
    else if (mmio_hit) begin
      case (off)
        2'd0:    data_d = cnt_q;
        2'd1:    data_d = {24'b0, led_q};
        2'd2:    data_d = {30'b0, status_q};
        default: data_d = '0;
      endcase
    end
`endif
  end

  // No reset on the array so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (reset && we_i && is_ram) begin
      mem[idx] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: tb/tb_memory_responder.sv
// Self-checking bench for memory_responder: directed scenarios then random traffic
// against a transaction-level model. Honours MEMORY_RESPONDER_MMIO_EN like the design.
module tb_memory_responder;

  localparam int unsigned D    = 1024;
  localparam logic [31:0] BASE = 32'hFFFF_FFF0;
`ifdef MEMORY_RESPONDER_MMIO_EN
  localparam bit MMIO_EN = 1'b1;
`else
  localparam bit MMIO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] data_i = '0;
  logic [31:0] data_o;
  logic [7:0]  led_o;

  memory_responder #(.DEPTH_WORDS(D), .MMIO_BASE(BASE)) dut (
    .clk    (clk),
    .reset  (reset),
    .we_i   (we_i),
    .addr_i (addr_i),
    .data_i (data_i),
    .data_o (data_o),
    .led_o  (led_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: memory image, MMIO registers, expected read data.
  logic [31:0] m_ram [D];
  logic [31:0] m_cnt = '0;
  logic [7:0]  m_led = '0;
  logic [1:0]  m_st  = '0;
  logic [31:0] m_exp = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic model(input bit rst_n, input bit we, input logic [31:0] a, input logic [31:0] d);
    bit unmapped, load;
    int unsigned off;
    if (!rst_n) begin
      m_exp = 0; m_cnt = 0; m_led = 0; m_st = 0;
      return;
    end
    unmapped = 0;
    load     = 0;
    m_exp    = 0;
    if (a < 4 * D) begin
      if (we) begin
        m_ram[a / 4] = d;
        m_exp = d;
      end else begin
        m_exp = m_ram[a / 4];
      end
    end else if (MMIO_EN && (a / 16) == (BASE / 16)) begin
      off = (a % 16) / 4;
      case (off)
        0: m_exp = m_cnt;
        1: m_exp = {24'b0, m_led};
        2: m_exp = {30'b0, m_st};
        default: m_exp = 0;
      endcase
      if (we) begin
        if (off == 0) load = 1;
        if (off == 1) m_led = d[7:0];
        if (off == 2) m_st = m_st & ~d[1:0];
      end
    end else begin
      unmapped = 1;
    end
    if (MMIO_EN) begin
      if (unmapped) m_st[0] = 1'b1;
      if (a % 4 != 0) m_st[1] = 1'b1;
      m_cnt = load ? d : m_cnt + 1;
    end
  endtask

  task automatic step(input bit rst_n, input bit we, input logic [31:0] a,
                      input logic [31:0] d, input string tag);
    reset  = rst_n;
    we_i   = we;
    addr_i = a;
    data_i = d;
    @(posedge clk);
    #1;
    model(rst_n, we, a, d);
    check({tag, "_data"}, data_o, m_exp);
    check({tag, "_led"}, {24'b0, led_o}, {24'b0, m_led});
  endtask

  initial begin
    logic [31:0] a, d;
    int unsigned r;

    step(0, 1, 32'h40, 32'h5555_AAAA, "rst_we");
    check("rst_data0", data_o, 32'h0);
    step(0, 0, 32'h0, 32'h0, "rst_idle");

    for (int i = 0; i < 64; i++) step(1, 1, 32'(i * 4), $urandom, "prewrite");

    // Write-first, then registered read.
    step(1, 1, 32'h10, 32'hDEAD_BEEF, "wr10");
    check("wr10_const", data_o, 32'hDEAD_BEEF);
    step(1, 0, 32'h10, 32'h0, "rd10");
    check("rd10_const", data_o, 32'hDEAD_BEEF);

    // Back-to-back reads without bubbles.
    step(1, 1, 32'h0, 32'd1, "pre0");
    step(1, 1, 32'h4, 32'd2, "pre4");
    step(1, 1, 32'h8, 32'd3, "pre8");
    step(1, 0, 32'h0, 32'h0, "b2b0");
    check("b2b0_const", data_o, 32'd1);
    step(1, 0, 32'h4, 32'h0, "b2b1");
    check("b2b1_const", data_o, 32'd2);
    step(1, 0, 32'h8, 32'h0, "b2b2");
    check("b2b2_const", data_o, 32'd3);

    // RAM range edges.
    step(1, 1, 32'(4 * D - 4), 32'hCAFE_F00D, "wrlast");
    step(1, 0, 32'(4 * D - 4), 32'h0, "rdlast");
    check("rdlast_const", data_o, 32'hCAFE_F00D);
    step(1, 0, 32'(4 * D), 32'h0, "rdpast");
    check("rdpast_const", data_o, 32'h0);

    step(1, 0, 32'h13, 32'h0, "rd13");
    check("rd13_const", data_o, 32'hDEAD_BEEF);

`ifdef MEMORY_RESPONDER_MMIO_EN
    step(1, 1, BASE + 8, 32'h3, "stclr");
    step(1, 0, 32'h0001_0000, 32'h0, "rdunmap");
    check("rdunmap_const", data_o, 32'h0);
    step(1, 0, BASE + 8, 32'h0, "st_unmap");
    check("st_unmap_const", data_o, 32'h1);
    step(1, 1, BASE + 8, 32'h1, "stclr1");
    step(1, 0, BASE + 8, 32'h0, "st_clear");
    check("st_clear_const", data_o, 32'h0);

    step(1, 0, 32'h13, 32'h0, "rd13b");
    step(1, 0, BASE + 8, 32'h0, "st_mis");
    check("st_mis_const", data_o, 32'h2);
    step(1, 1, BASE + 9, 32'h2, "clr_vs_set");
    step(1, 0, BASE + 8, 32'h0, "st_setwins");
    check("st_setwins_const", data_o, 32'h2);

    step(1, 1, BASE, 32'hFFFF_FFFE, "cntld");
    for (int i = 0; i < 3; i++) step(1, 0, 32'h0, 32'h0, "idle");
    step(1, 0, BASE, 32'h0, "cntwrap");
    check("cntwrap_const", data_o, 32'h1);

    step(1, 1, BASE + 4, 32'h0000_00A5, "ledwr");
    check("ledwr_const", {24'b0, led_o}, 32'hA5);
    step(0, 1, 32'h10, 32'h1234_5678, "midrst");
    check("midrst_led", {24'b0, led_o}, 32'h0);
    check("midrst_data", data_o, 32'h0);
    step(1, 0, BASE, 32'h0, "cntpost");
    check("cntpost_const", data_o, 32'h0);
`else
    step(1, 1, BASE + 4, 32'h0000_00A5, "ledwr_off");
    check("ledwr_off_const", {24'b0, led_o}, 32'h0);
    step(1, 0, BASE + 4, 32'h0, "ledrd_off");
    check("ledrd_off_const", data_o, 32'h0);
    step(1, 0, BASE + 8, 32'h0, "strd_off");
    check("strd_off_const", data_o, 32'h0);
    step(0, 1, 32'h10, 32'h1234_5678, "midrst");
    check("midrst_data", data_o, 32'h0);
`endif
    step(1, 0, 32'h10, 32'h0, "rd10_postrst");
    check("rd10_postrst_const", data_o, 32'hDEAD_BEEF);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      d = $urandom;
      a = 32'($urandom_range(0, 63) * 4);
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      case (r)
        0, 1, 2, 3: step(1, 0, a, d, "rnd_rd");
        4, 5:       step(1, 1, a, d, "rnd_wr");
        6:          step(1, $urandom_range(0, 1) == 1, $urandom_range(4 * D, 32'hFFFF_0000), d, "rnd_unmap");
        7, 8:       step(1, $urandom_range(0, 1) == 1, BASE + 32'($urandom_range(0, 15)), d, "rnd_mmio");
        default:    step($urandom_range(0, 3) != 0, 0, a, d, "rnd_rst");
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
